vga_frame_arbiter: RTL and testbench

Frame-granular arbiter that shares the `vga` pixel sink between two AXI-Stream pixel sources. It sits directly upstream of `vga`, drives its `pix_*` stream, and uses the `vga` `sof` pulse to schedule whole frames. Each frame goes to one source, chosen round-robin among sources parked at a start-of-frame pixel; otherwise the frame is a constant fill colour. Misaligned source data is dropped until the next start-of-frame; protocol violations abort to fill and are flagged.

---
 rtl/vga_frame_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vga_frame_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_arbiter.sv
// vga_frame_arbiter
// Shares the vga pixel sink between two AXI-Stream pixel sources, one whole
// frame at a time. On each vga start-of-frame pulse the next frame goes
// round-robin to a source that is parked on its first-of-frame pixel. If no
// source is parked, the frame is a constant fill colour. A granted source
// that loses framing (tuser/tlast disagreeing with the pixel position) is
// cut off to fill for the rest of that frame.
//
// Ports
//   aclk, aresetn        clock, asynchronous active-low reset
//   sof                  one-cycle start-of-frame pulse from vga
//   s0_* / s1_*          AXI-Stream pixel sources, tdata = {b,g,r}
//   m_*                  AXI-Stream pixel stream to vga (tlast/tuser regenerated)
//   grant                one-hot active source, 0 while idle or filling
//   err_clr              clears the sticky error flags
//   err_frame            sticky: granted source framing mismatch
//   err_sof              sticky: sof arrived while a frame was in progress
module vga_frame_arbiter #(
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter logic [11:0] FILL_COLOR = 12'h000
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            sof,
  input  logic            s0_tvalid,
  output logic            s0_tready,
  input  logic [2:0][3:0] s0_tdata,
  input  logic            s0_tlast,
  input  logic            s0_tuser,
  input  logic            s1_tvalid,
  output logic            s1_tready,
  input  logic [2:0][3:0] s1_tdata,
  input  logic            s1_tlast,
  input  logic            s1_tuser,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic [2:0][3:0] m_tdata,
  output logic            m_tlast,
  output logic            m_tuser,
  output logic [1:0]      grant,
  input  logic            err_clr,
  output logic            err_frame,
  output logic            err_sof
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, FILL} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          gsel_q, gsel_d;             // granted source index while in STREAM
  logic          last_grant_q, last_grant_d; // source that received the previous grant
  logic          err_frame_q, err_frame_d;
  logic          err_sof_q, err_sof_d;

  logic            first_px, last_x, last_y;
  logic            req0, req1, pick;
  logic            sel_valid, sel_user, sel_last;
  logic [2:0][3:0] sel_data;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      gsel_q       <= 1'b0;
      last_grant_q <= 1'b1;  // s0 wins the first contention
      err_frame_q  <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gsel_q       <= gsel_d;
      last_grant_q <= last_grant_d;
      err_frame_q  <= err_frame_d;
      err_sof_q    <= err_sof_d;
    end
  end

  assign first_px = (x_q == '0) && (y_q == '0);
  assign last_x   = (x_q == XW'(H_RES - 1));
  assign last_y   = (y_q == YW'(V_RES - 1));

  // A source counts as requesting only while parked on its first-of-frame beat.
  assign req0 = s0_tvalid && s0_tuser;
  assign req1 = s1_tvalid && s1_tuser;
  assign pick = (req0 && req1) ? ~last_grant_q : req1;

  assign sel_valid = gsel_q ? s1_tvalid : s0_tvalid;
  assign sel_data  = gsel_q ? s1_tdata  : s0_tdata;
  assign sel_user  = gsel_q ? s1_tuser  : s0_tuser;
  assign sel_last  = gsel_q ? s1_tlast  : s0_tlast;

  assign m_tuser   = first_px;
  assign m_tlast   = last_x;
  assign err_frame = err_frame_q;
  assign err_sof   = err_sof_q;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    gsel_d       = gsel_q;
    last_grant_d = last_grant_q;
    err_frame_d  = err_frame_q && !err_clr;
    err_sof_d    = err_sof_q && !err_clr;
    m_tvalid     = 1'b0;
    m_tdata      = FILL_COLOR;
    grant        = 2'b00;
    // Non-granted sources: drop anything that is not a first-of-frame beat.
    s0_tready    = s0_tvalid && !s0_tuser;
    s1_tready    = s1_tvalid && !s1_tuser;

    case (state_q)
      IDLE: begin
        if (sof) begin
          if (req0 || req1) begin
            state_d      = STREAM;
            gsel_d       = pick;
            last_grant_d = pick;
          end else begin
            state_d = FILL;
          end
        end
      end
      STREAM: begin
        m_tvalid = sel_valid;
        m_tdata  = sel_data;
        grant    = gsel_q ? 2'b10 : 2'b01;
        if (gsel_q) s1_tready = m_tready;
        else        s0_tready = m_tready;
        // The offending beat itself is still forwarded; fill takes over after it.
        if (sel_valid && m_tready && ((sel_user != first_px) || (sel_last != last_x))) begin
          err_frame_d = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        m_tvalid = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (m_tvalid && m_tready) begin
      if (last_x) begin
        x_d = '0;
        y_d = last_y ? '0 : y_q + 1'b1;
        if (last_y) state_d = IDLE;  // frame end wins over a same-beat mismatch
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    if (sof && (state_q != IDLE)) err_sof_d = 1'b1;
  end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// Directed testbench for vga_frame_arbiter with a 4x2 frame.
module tb_vga_frame_arbiter;

  localparam int          H = 4;
  localparam int          V = 2;
  localparam logic [11:0] FILL = 12'hABC;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic            sof;
  logic            s0_tvalid, s0_tready, s0_tlast, s0_tuser;
  logic            s1_tvalid, s1_tready, s1_tlast, s1_tuser;
  logic [2:0][3:0] s0_tdata, s1_tdata;
  logic            m_tvalid, m_tready, m_tlast, m_tuser;
  logic [2:0][3:0] m_tdata;
  logic [1:0]      grant;
  logic            err_clr, err_frame, err_sof;

  int vectors = 0;
  int miscompares = 0;

  vga_frame_arbiter #(.H_RES(H), .V_RES(V), .FILL_COLOR(FILL)) dut (
    .aclk(aclk), .aresetn(aresetn), .sof(sof),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
    .s0_tlast(s0_tlast), .s0_tuser(s0_tuser),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
    .s1_tlast(s1_tlast), .s1_tuser(s1_tuser),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .grant(grant), .err_clr(err_clr), .err_frame(err_frame), .err_sof(err_sof)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src(input int g, input logic v, input logic [11:0] d,
                           input logic u, input logic l);
    if (g == 0) begin
      s0_tvalid = v; s0_tdata = d; s0_tuser = u; s0_tlast = l;
    end else begin
      s1_tvalid = v; s1_tdata = d; s1_tuser = u; s1_tlast = l;
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Assert sof on the next falling edge; the block must still be idle then.
  task automatic pulse_sof();
    @(negedge aclk);
    sof = 1'b1;
    #1;
    check("idle_tvalid", 32'(m_tvalid), 32'd0);
    $display("sof pulse at %0t", $time);
  endtask

  // Run one 8-beat frame following a sof pulse. g<0 means a fill frame.
  // bad_beat>=0 flips tlast on that beat; sof_beat>=0 re-pulses sof mid-frame.
  task automatic run_frame(input int g, input logic [11:0] base,
                           input int bad_beat, input int sof_beat);
    int fill_from;
    logic [11:0] exp_data;
    fill_from = (g < 0) ? 0 : ((bad_beat >= 0) ? bad_beat + 1 : H * V);
    for (int k = 0; k < H * V; k++) begin
      @(negedge aclk);
      sof = (k == sof_beat);
      if (g >= 0)
        drive_src(g, 1'b1, 12'(base + 12'(k)), (k == 0),
                  ((k % H) == H - 1) ^ (k == bad_beat));
      #1;
      exp_data = (k >= fill_from) ? FILL : 12'(base + 12'(k));
      check("beat_tvalid", 32'(m_tvalid), 32'd1);
      check("beat_tdata",  32'(m_tdata),  32'(exp_data));
      check("beat_tuser",  32'(m_tuser),  32'(k == 0));
      check("beat_tlast",  32'(m_tlast),  32'((k % H) == H - 1));
      check("beat_grant",  32'(grant),
            (k >= fill_from) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2));
      if (bad_beat >= 0 && k == bad_beat + 1)
        check("err_frame_set", 32'(err_frame), 32'd1);
      $display("beat %0d src %0d data %0h user %0b last %0b grant %0b",
               k, g, m_tdata, m_tuser, m_tlast, grant);
    end
    @(negedge aclk);
    sof = 1'b0;
    if (g >= 0) drive_src(g, 1'b0, 12'h000, 1'b0, 1'b0);
    #1;
    check("end_idle_tvalid", 32'(m_tvalid), 32'd0);
    check("end_idle_grant",  32'(grant),    32'd0);
  endtask

  initial begin
    aresetn = 1'b0; sof = 1'b0; m_tready = 1'b1; err_clr = 1'b0;
    drive_src(0, 1'b1, 12'h000, 1'b0, 1'b0);
    drive_src(1, 1'b0, 12'h000, 1'b0, 1'b0);
    #1;
    // Reset state
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tlast",  32'(m_tlast),  32'd0);
    check("rst_tuser",  32'(m_tuser),  32'd1);
    check("rst_tdata",  32'(m_tdata),  32'(FILL));
    check("rst_grant",  32'(grant),    32'd0);
    check("rst_errs",   32'({err_frame, err_sof}), 32'd0);
    check("rst_s0_tready_drop", 32'(s0_tready), 32'd1);
    $display("reset checked");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;

    // 1: s0 alone, correct frame
    @(negedge aclk);
    drive_src(0, 1'b1, 12'h100, 1'b1, 1'b0);
    #1;
    check("s0_parked_tready", 32'(s0_tready), 32'd0);
    pulse_sof();
    run_frame(0, 12'h100, -1, -1);
    check("frame1_errs", 32'({err_frame, err_sof}), 32'd0);

    // 2: both parked, three contended frames from reset -> s0, s1, s0
    do_reset();
    for (int f = 0; f < 3; f++) begin
      @(negedge aclk);
      drive_src(0, 1'b1, 12'h100, 1'b1, 1'b0);
      drive_src(1, 1'b1, 12'h200, 1'b1, 1'b0);
      pulse_sof();
      run_frame(f % 2, (f % 2 == 0) ? 12'h100 : 12'h200, -1, -1);
    end
    drive_src(0, 1'b0, 12'h000, 1'b0, 1'b0);
    drive_src(1, 1'b0, 12'h000, 1'b0, 1'b0);

    // 3: nobody valid -> fill frame
    pulse_sof();
    run_frame(-1, 12'h000, -1, -1);

    // 4: s1 misaligned beats are dropped, SOF beat is held
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      drive_src(1, 1'b1, 12'(12'h300 + 12'(k)), 1'b0, 1'b0);
      #1;
      check("s1_drop_tready", 32'(s1_tready), 32'd1);
      $display("s1 drop beat %0d tready %0b", k, s1_tready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      drive_src(1, 1'b1, 12'h300, 1'b1, 1'b0);
      #1;
      check("s1_hold_tready", 32'(s1_tready), 32'd0);
      check("s1_hold_tvalid", 32'(m_tvalid), 32'd0);
      $display("s1 hold cycle %0d tready %0b", k, s1_tready);
    end
    drive_src(1, 1'b0, 12'h000, 1'b0, 1'b0);

    // 5: s0 granted (last grant was s0 at contention end, but s0 alone requests),
    //    bad tlast on beat 2 -> fill from beat 3, then err_clr
    @(negedge aclk);
    drive_src(0, 1'b1, 12'h400, 1'b1, 1'b0);
    pulse_sof();
    run_frame(0, 12'h400, 2, -1);
    check("err_frame_held", 32'(err_frame), 32'd1);
    @(negedge aclk);
    err_clr = 1'b1;
    @(negedge aclk);
    err_clr = 1'b0;
    #1;
    check("err_frame_cleared", 32'(err_frame), 32'd0);
    $display("err_clr applied, err_frame %0b", err_frame);

    // 6: sof mid-stream flags err_sof, frame completes unaffected
    @(negedge aclk);
    drive_src(0, 1'b1, 12'h500, 1'b1, 1'b0);
    pulse_sof();
    run_frame(0, 12'h500, -1, 3);
    check("err_sof_set", 32'(err_sof), 32'd1);
    check("err_frame_clear", 32'(err_frame), 32'd0);

    // Reset asserted mid-frame
    @(negedge aclk);
    drive_src(0, 1'b1, 12'h600, 1'b1, 1'b0);
    pulse_sof();
    @(negedge aclk);
    sof = 1'b0;
    drive_src(0, 1'b1, 12'h600, 1'b1, 1'b0);
    @(negedge aclk);
    drive_src(0, 1'b1, 12'h601, 1'b0, 1'b0);
    #1;
    check("mid_grant", 32'(grant), 32'd1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("midrst_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_grant",  32'(grant),    32'd0);
    check("midrst_errs",   32'({err_frame, err_sof}), 32'd0);
    check("midrst_tuser",  32'(m_tuser),  32'd1);
    $display("mid-frame reset: tvalid %0b grant %0b", m_tvalid, grant);
    @(negedge aclk);
    aresetn = 1'b1;
    drive_src(0, 1'b0, 12'h000, 1'b0, 1'b0);
    @(negedge aclk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
